// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register block.
// Optional accumulate feature is enabled by defining HILO_ACC_EN.
package hilo_pkg;

    localparam int HILO_MAX_WP = 4;
    localparam int HILO_DW     = 32;

    typedef struct packed {
        logic [HILO_DW-1:0] hi;
        logic [HILO_DW-1:0] lo;
    } hilo_data_t;

    typedef struct packed {
        hilo_data_t data;
        logic       hi_v;
        logic       lo_v;
    } hilo_pend_t;

endpackage

// File: rtl/hilo_acc_unit.sv
// Combinational MADD/MSUB datapath for the HI/LO block.
// Present only when HILO_ACC_EN is defined.
`ifdef HILO_ACC_EN
module hilo_acc_unit #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic                i_sub,
    input  logic                i_signed,
    output logic [2*DATA_W-1:0] o_res
);

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_a_sx;
    logic                w_b_sx;

    assign w_a_sx  = i_signed & i_a[DATA_W-1];
    assign w_b_sx  = i_signed & i_b[DATA_W-1];
    assign w_a_ext = {{DATA_W{w_a_sx}}, i_a};
    assign w_b_ext = {{DATA_W{w_b_sx}}, i_b};

    // Low 2W bits of the extended product are the same for signed and unsigned.
    assign w_prod = w_a_ext * w_b_ext;
    assign o_res  = i_sub ? (i_acc - w_prod) : (i_acc + w_prod);

endmodule
`endif

// File: rtl/hilo_regfile_mp.sv
// Multi-lane HI/LO register with one speculative pending stage and flush.
// Define HILO_ACC_EN to add the MADD/MSUB accumulate path.
module hilo_regfile_mp
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_DW,
    parameter int NUM_WP = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WP-1:0]        wr_hi_en,
    input  logic [NUM_WP-1:0]        wr_lo_en,
    input  logic [NUM_WP*DATA_W-1:0] wr_hi,
    input  logic [NUM_WP*DATA_W-1:0] wr_lo,
    input  logic                     flush,
    output logic [DATA_W-1:0]        hi_o,
    output logic [DATA_W-1:0]        lo_o,
    output logic [DATA_W-1:0]        arch_hi_o,
    output logic [DATA_W-1:0]        arch_lo_o,
    output logic                     pend_valid,
    input  logic                     acc_valid,
    input  logic                     acc_sub,
    input  logic                     acc_signed,
    input  logic [DATA_W-1:0]        acc_a,
    input  logic [DATA_W-1:0]        acc_b
);

    hilo_pend_t r_pend;
    hilo_pend_t w_nxt;
    hilo_data_t r_arch;
    hilo_data_t w_fwd;

    assign w_fwd.hi = r_pend.hi_v ? r_pend.data.hi : r_arch.hi;
    assign w_fwd.lo = r_pend.lo_v ? r_pend.data.lo : r_arch.lo;

`ifdef HILO_ACC_EN
    logic [2*DATA_W-1:0] w_acc_res;

    hilo_acc_unit #(
        .DATA_W   (DATA_W)
    ) u_acc (
        .i_acc    (w_fwd),
        .i_a      (acc_a),
        .i_b      (acc_b),
        .i_sub    (acc_sub),
        .i_signed (acc_signed),
        .o_res    (w_acc_res)
    );
`else
    logic w_unused_acc;
    assign w_unused_acc = ^{acc_valid, acc_sub, acc_signed, acc_a, acc_b};
`endif

    // Later assignments win: lane 0, then acc, then younger lanes.
    always_comb begin
        w_nxt = '0;
        if (wr_hi_en[0]) begin
            w_nxt.data.hi = wr_hi[DATA_W-1:0];
            w_nxt.hi_v    = 1'b1;
        end
        if (wr_lo_en[0]) begin
            w_nxt.data.lo = wr_lo[DATA_W-1:0];
            w_nxt.lo_v    = 1'b1;
        end
`ifdef HILO_ACC_EN
        if (acc_valid) begin
            w_nxt.data = w_acc_res;
            w_nxt.hi_v = 1'b1;
            w_nxt.lo_v = 1'b1;
        end
`endif
        for (int i = 1; i < NUM_WP; i++) begin
            if (wr_hi_en[i]) begin
                w_nxt.data.hi = wr_hi[i*DATA_W +: DATA_W];
                w_nxt.hi_v    = 1'b1;
            end
            if (wr_lo_en[i]) begin
                w_nxt.data.lo = wr_lo[i*DATA_W +: DATA_W];
                w_nxt.lo_v    = 1'b1;
            end
        end
        if (flush) begin
            w_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
            r_arch <= '0;
        end else begin
            if (!flush && r_pend.hi_v) begin
                r_arch.hi <= r_pend.data.hi;
            end
            if (!flush && r_pend.lo_v) begin
                r_arch.lo <= r_pend.data.lo;
            end
            r_pend <= w_nxt;
        end
    end

    assign hi_o       = w_fwd.hi;
    assign lo_o       = w_fwd.lo;
    assign arch_hi_o  = r_arch.hi;
    assign arch_lo_o  = r_arch.lo;
    assign pend_valid = r_pend.hi_v | r_pend.lo_v;

endmodule

// File: tb/tb_hilo_regfile_mp.sv
// Scoreboard bench for hilo_regfile_mp with a cycle-level reference model.
// Accumulate checks are included when HILO_ACC_EN is defined.
module tb_hilo_regfile_mp;

    localparam int DW  = 32;
    localparam int NWP = 2;
`ifdef HILO_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [NWP-1:0]    wr_hi_en;
    logic [NWP-1:0]    wr_lo_en;
    logic [NWP*DW-1:0] wr_hi;
    logic [NWP*DW-1:0] wr_lo;
    logic              flush;
    logic [DW-1:0]     hi_o;
    logic [DW-1:0]     lo_o;
    logic [DW-1:0]     arch_hi_o;
    logic [DW-1:0]     arch_lo_o;
    logic              pend_valid;
    logic              acc_valid;
    logic              acc_sub;
    logic              acc_signed;
    logic [DW-1:0]     acc_a;
    logic [DW-1:0]     acc_b;

    hilo_regfile_mp #(
        .DATA_W     (DW),
        .NUM_WP     (NWP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_hi_en   (wr_hi_en),
        .wr_lo_en   (wr_lo_en),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .flush      (flush),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .arch_hi_o  (arch_hi_o),
        .arch_lo_o  (arch_lo_o),
        .pend_valid (pend_valid),
        .acc_valid  (acc_valid),
        .acc_sub    (acc_sub),
        .acc_signed (acc_signed),
        .acc_a      (acc_a),
        .acc_b      (acc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [DW-1:0] ahi;
        logic [DW-1:0] alo;
        logic          pv;
    } exp_t;

    exp_t exp_q[$];
    int   errs   = 0;
    int   checks = 0;

    logic [DW-1:0] m_ahi, m_alo, m_ph, m_pl;
    logic          m_phv, m_plv;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [2*DW-1:0] acc_model(
        input logic [2*DW-1:0] fwd, input logic [DW-1:0] a,
        input logic [DW-1:0] b, input logic sub, input logic sgn);
        logic signed [2*DW-1:0] p;
        if (sgn) p = $signed(a) * $signed(b);
        else     p = a * b;
        return sub ? fwd - p : fwd + p;
    endfunction

    task automatic model_reset();
        m_ahi = '0; m_alo = '0; m_ph = '0; m_pl = '0;
        m_phv = 1'b0; m_plv = 1'b0;
    endtask

    task automatic model_step();
        int            hl, ll;
        logic          av;
        logic [2*DW-1:0] ar;
        logic [DW-1:0] nh, nl;
        logic          nhv, nlv;
        exp_t          e;
        hl = -1; ll = -1;
        nh = '0; nl = '0; nhv = 1'b0; nlv = 1'b0;
        av = ACC && acc_valid;
        ar = acc_model({m_phv ? m_ph : m_ahi, m_plv ? m_pl : m_alo},
                       acc_a, acc_b, acc_sub, acc_signed);
        for (int i = NWP - 1; i >= 0; i--) begin
            if (hl < 0 && wr_hi_en[i]) hl = i;
            if (ll < 0 && wr_lo_en[i]) ll = i;
        end
        if (!flush) begin
            if (hl >= 1 || (hl == 0 && !av)) begin
                nhv = 1'b1; nh = wr_hi[hl*DW +: DW];
            end else if (av) begin
                nhv = 1'b1; nh = ar[2*DW-1:DW];
            end
            if (ll >= 1 || (ll == 0 && !av)) begin
                nlv = 1'b1; nl = wr_lo[ll*DW +: DW];
            end else if (av) begin
                nlv = 1'b1; nl = ar[DW-1:0];
            end
            if (m_phv) m_ahi = m_ph;
            if (m_plv) m_alo = m_pl;
        end
        m_ph = nh; m_pl = nl; m_phv = nhv; m_plv = nlv;
        e.hi  = m_phv ? m_ph : m_ahi;
        e.lo  = m_plv ? m_pl : m_alo;
        e.ahi = m_ahi;
        e.alo = m_alo;
        e.pv  = m_phv | m_plv;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_hi_en = '0; wr_lo_en = '0; wr_hi = '0; wr_lo = '0;
        flush = 1'b0; acc_valid = 1'b0; acc_sub = 1'b0;
        acc_signed = 1'b0; acc_a = '0; acc_b = '0;
    endtask

    task automatic set_hi(input int ln, input logic [DW-1:0] v);
        wr_hi_en[ln] = 1'b1;
        wr_hi[ln*DW +: DW] = v;
    endtask

    task automatic set_lo(input int ln, input logic [DW-1:0] v);
        wr_lo_en[ln] = 1'b1;
        wr_lo[ln*DW +: DW] = v;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_hi_o"}, hi_o, 0);
        chk({nm, "_lo_o"}, lo_o, 0);
        chk({nm, "_arch_hi"}, arch_hi_o, 0);
        chk({nm, "_arch_lo"}, arch_lo_o, 0);
        chk({nm, "_pend_valid"}, pend_valid, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_hi_o", hi_o, e.hi);
                chk("sb_lo_o", lo_o, e.lo);
                chk("sb_arch_hi", arch_hi_o, e.ahi);
                chk("sb_arch_lo", arch_lo_o, e.alo);
                chk("sb_pend_valid", pend_valid, e.pv);
            end
        end
    end

    initial begin : stim
        rst = 1'b0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        idle(); set_hi(0, 32'h1111); set_hi(1, 32'h2222); tick();
        chk("dual_hi_fwd", hi_o, 32'h2222);
        idle(); tick();
        chk("dual_arch_hi", arch_hi_o, 32'h2222);

        idle(); set_lo(0, 32'hAAAA); set_hi(1, 32'hBBBB); tick();
        idle(); tick();
        chk("split_arch_lo", arch_lo_o, 32'hAAAA);
        chk("split_arch_hi", arch_hi_o, 32'hBBBB);

        idle(); set_hi(0, 32'h5); tick();
        chk("flush_fwd", hi_o, 32'h5);
        idle(); flush = 1'b1; tick();
        idle();
        chk("flush_arch_hi", arch_hi_o, 32'hBBBB);
        chk("flush_hi_o", hi_o, 32'hBBBB);

        for (int k = 1; k <= 3; k++) begin
            idle(); set_hi(0, k); tick();
            if (k > 1) chk("b2b_arch_hi", arch_hi_o, k - 1);
        end
        idle(); tick();
        chk("b2b_arch_hi", arch_hi_o, 3);

        idle(); set_hi(0, 32'h77); set_lo(1, 32'h88); tick();
        #2 rst = 1'b0;
        #1 chk_zero("midreset");
        model_reset();
        set_hi(0, 32'h99);
        @(posedge clk); @(negedge clk);
        chk("rst_hold_hi_o", hi_o, 0);
        idle();
        rst = 1'b1;

`ifdef HILO_ACC_EN
        idle(); acc_valid = 1'b1; acc_signed = 1'b1;
        acc_a = 32'hFFFF_FFFE; acc_b = 32'd3; tick();
        chk("madd_signed", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        idle(); acc_valid = 1'b1; acc_sub = 1'b1;
        acc_a = 32'hFFFF_FFFF; acc_b = 32'hFFFF_FFFF; tick();
        chk("msub_unsigned", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFF9);
        idle(); tick();
`endif

        repeat (400) begin
            idle();
            wr_hi_en = NWP'($urandom);
            wr_lo_en = NWP'($urandom);
            for (int i = 0; i < NWP; i++) begin
                wr_hi[i*DW +: DW] = $urandom;
                wr_lo[i*DW +: DW] = $urandom;
            end
            flush      = ($urandom_range(0, 9) == 0);
            acc_valid  = ($urandom_range(0, 3) == 0);
            acc_sub    = 1'($urandom);
            acc_signed = 1'($urandom);
            acc_a      = $urandom;
            acc_b      = $urandom;
            tick();
        end
        idle();
        repeat (3) tick();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
